// File: rtl/gcm_pkg.sv
// gcm_pkg: shared GF(2^128) definitions for the GCM datapath.
// Latency: n/a (types, constants and combinational helpers only).
// Backpressure: n/a.
// Contents: FSM state type, reduction constant GF128_R, gf128_shr (multiply by x),
//           digit_legal (legal DIGIT widths for the digit-serial multiplier).
package gcm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } gf_state_t;

  // GCM bit order: index 0 is the x^0 coefficient, so the polynomial
  // 1 + x + x^2 + x^7 shows up as E1 in the leftmost byte.
  localparam logic [0:127] GF128_R = {8'hE1, 120'h0};

  // Multiply by x modulo x^128 + x^7 + x^2 + x + 1. A right shift moves every
  // coefficient one power up; the x^128 term that falls off folds back as R.
  function automatic logic [0:127] gf128_shr(input logic [0:127] v);
    gf128_shr = (v >> 1) ^ (v[127] ? GF128_R : 128'h0);
  endfunction

  function automatic bit digit_legal(input int d);
    return (d == 1) || (d == 2) || (d == 4) || (d == 8) || (d == 16) || (d == 32);
  endfunction

endpackage

// File: rtl/gfmul_digit_step.sv
// gfmul_digit_step: one DIGIT-bit unrolled step of the GF(2^128) shift-and-add multiplier.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, the caller decides when to register.
// Ports: z/v   current partial product and shifted key,
//        a     next DIGIT multiplicand bits (a[0] processed first),
//        z_nxt/v_nxt  values after DIGIT single-bit steps.
module gfmul_digit_step
  import gcm_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [0:127]     z,
  input  logic [0:127]     v,
  input  logic [0:DIGIT-1] a,
  output logic [0:127]     z_nxt,
  output logic [0:127]     v_nxt
);

  logic [0:127] z_acc;
  logic [0:127] v_acc;

  // Bit k must see V already advanced k times, so the chain is strictly ordered.
  always_comb begin
    z_acc = z;
    v_acc = v;
    for (int k = 0; k < DIGIT; k++) begin
      if (a[k]) begin
        z_acc = z_acc ^ v_acc;
      end
      v_acc = gf128_shr(v_acc);
    end
  end

  assign z_nxt = z_acc;
  assign v_nxt = v_acc;

endmodule

// File: rtl/gfmul_digit.sv
// gfmul_digit: digit-serial GF(2^128) multiplier Y <- (X [^ Y]) * H for GHASH.
// Latency: accept edge, then N = 128/DIGIT compute edges; oResult_valid pulses the cycle after.
// Backpressure: oX_ready low for the N busy cycles; a new block may be accepted in the DONE cycle.
// Ports: iClk/iRst (sync, active-high); iH/iH_load key load; iX/iX_valid/oX_ready block
//        handshake; iAccum fold Y into the multiplicand; iClear zero Y;
//        oResult = Y, oResult_valid completion pulse, oBusy high while computing.
module gfmul_digit
  import gcm_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic [0:127] iH,
  input  logic         iH_load,
  input  logic [0:127] iX,
  input  logic         iX_valid,
  output logic         oX_ready,
  input  logic         iAccum,
  input  logic         iClear,
  output logic [0:127] oResult,
  output logic         oResult_valid,
  output logic         oBusy
);

  localparam int N     = 128 / DIGIT;
  localparam int CNT_W = $clog2(N) + 1;

  if (!digit_legal(DIGIT)) begin : g_bad_digit
    $error("gfmul_digit: DIGIT must be one of 1, 2, 4, 8, 16, 32");
  end

  gf_state_t        state_q;
  logic [0:127]     h_q;
  logic [0:127]     a_q;
  logic [0:127]     z_q;
  logic [0:127]     v_q;
  logic [0:127]     y_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             busy_q;
  logic             rv_q;

  logic             accept;
  logic             last_step;
  logic [0:127]     a_init;
  logic [0:127]     v_init;
  logic [0:127]     z_nxt;
  logic [0:127]     v_nxt;

  assign accept    = iX_valid && (state_q != ST_BUSY);
  assign last_step = (cnt_q == CNT_W'(N - 1));
  // A clear in the accept cycle wins over accumulation: the block starts a fresh chain.
  assign a_init    = iX ^ ((iAccum && !iClear) ? y_q : 128'h0);
  // A key loaded together with an accept is bypassed straight into V.
  assign v_init    = iH_load ? iH : h_q;

  // A is consumed from index 0 and shifted toward it, so the step always sees a_q[0:DIGIT-1].
  gfmul_digit_step #(
    .DIGIT (DIGIT)
  ) u_step (
    .z     (z_q),
    .v     (v_q),
    .a     (a_q[0:DIGIT-1]),
    .z_nxt (z_nxt),
    .v_nxt (v_nxt)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      a_q     <= '0;
      z_q     <= '0;
      v_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      if (iClear) begin
        y_q <= '0;
      end
      // The key is frozen while BUSY so an in-flight product never mixes two keys.
      if (iH_load && (state_q != ST_BUSY)) begin
        h_q <= iH;
      end
      case (state_q)
        ST_BUSY: begin
          z_q   <= z_nxt;
          v_q   <= v_nxt;
          a_q   <= a_q << DIGIT;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            // Written after the clear above, so a completion beats a same-cycle clear.
            y_q     <= z_nxt;
            state_q <= ST_DONE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            rv_q    <= 1'b1;
          end
        end
        default: begin
          if (accept) begin
            a_q     <= a_init;
            z_q     <= '0;
            v_q     <= v_init;
            cnt_q   <= '0;
            state_q <= ST_BUSY;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign oX_ready      = ready_q;
  assign oBusy         = busy_q;
  assign oResult_valid = rv_q;
  assign oResult       = y_q;

endmodule

// File: tb/tb_gfmul_digit.sv
// tb_gfmul_digit: directed and random checks of gfmul_digit for DIGIT = 1, 8 and 32.
// Each instance is exercised in turn; data inputs are shared, iX_valid is per instance.
module tb_gfmul_digit;

  localparam logic [0:127] H_TC2 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [0:127] X_TC2 = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [0:127] Y_1   = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [0:127] Y_2   = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam logic [0:127] X_LEN = 128'h00000000000000000000000000000080;
  localparam logic [0:127] ONE   = 128'h80000000000000000000000000000000;

  logic iClk = 1'b0;
  always #5 iClk = ~iClk;

  logic         iRst;
  logic         iH_load;
  logic         iAccum;
  logic         iClear;
  logic [0:127] iH;
  logic [0:127] iX;
  logic         xv   [3];
  logic         rdy  [3];
  logic         rv   [3];
  logic         busy [3];
  logic [0:127] res  [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  gfmul_digit #(.DIGIT(1)) u_d1 (
    .iClk(iClk), .iRst(iRst), .iH(iH), .iH_load(iH_load), .iX(iX), .iX_valid(xv[0]),
    .oX_ready(rdy[0]), .iAccum(iAccum), .iClear(iClear), .oResult(res[0]),
    .oResult_valid(rv[0]), .oBusy(busy[0]));

  gfmul_digit #(.DIGIT(8)) u_d8 (
    .iClk(iClk), .iRst(iRst), .iH(iH), .iH_load(iH_load), .iX(iX), .iX_valid(xv[1]),
    .oX_ready(rdy[1]), .iAccum(iAccum), .iClear(iClear), .oResult(res[1]),
    .oResult_valid(rv[1]), .oBusy(busy[1]));

  gfmul_digit #(.DIGIT(32)) u_d32 (
    .iClk(iClk), .iRst(iRst), .iH(iH), .iH_load(iH_load), .iX(iX), .iX_valid(xv[2]),
    .oX_ready(rdy[2]), .iAccum(iAccum), .iClear(iClear), .oResult(res[2]),
    .oResult_valid(rv[2]), .oBusy(busy[2]));

  function automatic int dig(input int d);
    return (d == 0) ? 1 : (d == 1) ? 8 : 32;
  endfunction

  function automatic int n_of(input int d);
    return 128 / dig(d);
  endfunction

  // Bit-serial GCM reference product.
  function automatic logic [0:127] gf_ref(input logic [0:127] x, input logic [0:127] h);
    logic [0:127] z;
    logic [0:127] v;
    z = '0;
    v = h;
    for (int i = 0; i < 128; i++) begin
      if (x[i]) z = z ^ v;
      v = v[127] ? ((v >> 1) ^ {8'hE1, 120'h0}) : (v >> 1);
    end
    return z;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge iClk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input int d, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s (DIGIT=%0d): observed=%h expected=%h", tag, dig(d), obs, exp);
    end
  endtask

  task automatic load_key(input logic [0:127] h);
    iH = h;
    iH_load = 1'b1;
    tick();
    iH_load = 1'b0;
  endtask

  // Offer one block to instance d (which must be ready) and pass the accept edge.
  task automatic start(input int d, input logic [0:127] x, input logic acc,
                       input logic hl, input logic [0:127] h, input logic clr);
    iX = x; iAccum = acc; iH = h; iH_load = hl; iClear = clr;
    xv[d] = 1'b1;
    tick();
    xv[d] = 1'b0; iH_load = 1'b0; iClear = 1'b0; iAccum = 1'b0; iX = '0;
    acc_cyc = cyc;
  endtask

  // Wait (bounded) for the completion pulse; latency is counted in edges after the accept edge.
  task automatic wait_done(input int d, output logic [0:127] y);
    int lat;
    lat = -1;
    for (int c = 0; c < n_of(d) + 6; c++) begin
      if (rv[d]) begin
        lat = cyc - acc_cyc;
        break;
      end
      tick();
    end
    chk("latency", d, lat, n_of(d));
    y = res[d];
  endtask

  task automatic run_block(input int d, input logic [0:127] x, input logic acc,
                           input logic hl, input logic [0:127] h, input logic clr,
                           output logic [0:127] y);
    start(d, x, acc, hl, h, clr);
    wait_done(d, y);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [0:127] y;
    logic [0:127] my;
    logic [0:127] hc;
    logic [0:127] x;
    logic         acc;
    logic         hl;
    int           p;
    int           lows;
    int           last;
    int           base;
    int           n;
    int           iters;

    iRst = 1'b1; iH_load = 1'b0; iAccum = 1'b0; iClear = 1'b0; iH = '0; iX = '0;
    for (int d = 0; d < 3; d++) xv[d] = 1'b0;
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      chk("reset_ready", d, rdy[d], 1);
      chk("reset_busy", d, busy[d], 0);
      chk("reset_valid", d, rv[d], 0);
      chk("reset_result", d, res[d], 0);
    end
    iRst = 1'b0;
    tick();

    for (int d = 0; d < 3; d++) begin
      n = n_of(d);

      // Identity key: product equals X.
      load_key(ONE);
      run_block(d, X_TC2, 1'b0, 1'b0, '0, 1'b0, y);
      chk("identity", d, y, X_TC2);

      // GHASH chain, GCM test case 2.
      load_key(H_TC2);
      iClear = 1'b1;
      tick();
      iClear = 1'b0;
      chk("clear_idle", d, res[d], 0);
      run_block(d, X_TC2, 1'b1, 1'b0, '0, 1'b0, y);
      chk("ghash_blk1", d, y, Y_1);
      run_block(d, X_LEN, 1'b1, 1'b0, '0, 1'b0, y);
      chk("ghash_len", d, y, Y_2);

      // Continuous iX_valid across three blocks.
      iX = X_TC2; iAccum = 1'b0; xv[d] = 1'b1;
      p = 0; lows = 0; last = 0; base = cyc;
      for (int c = 0; c < 3 * (n + 1) + 8 && p < 3; c++) begin
        tick();
        if (!rdy[d]) lows++;
        if (rv[d]) begin
          p++;
          chk("hs_result", d, res[d], Y_1);
          if (p == 1) chk("hs_first_pulse", d, cyc - base, n + 1);
          else        chk("hs_spacing", d, cyc - last, n + 1);
          last = cyc;
        end
      end
      xv[d] = 1'b0;
      chk("hs_pulses", d, p, 3);
      chk("hs_ready_low", d, lows, 3 * n);
      tick();
      chk("hs_idle_ready", d, rdy[d], 1);
      chk("hs_idle_busy", d, busy[d], 0);

      // Key load while BUSY is ignored, for this and the next block.
      start(d, X_TC2, 1'b0, 1'b0, '0, 1'b0);
      tick();
      chk("busy_flag", d, busy[d], 1);
      iH = ONE; iH_load = 1'b1;
      tick();
      iH_load = 1'b0;
      wait_done(d, y);
      chk("hload_busy", d, y, Y_1);
      run_block(d, X_TC2, 1'b0, 1'b0, '0, 1'b0, y);
      chk("hload_busy_kept", d, y, Y_1);

      // Key load with accept is bypassed into that operation.
      run_block(d, X_TC2, 1'b0, 1'b1, ONE, 1'b0, y);
      chk("hload_accept_one", d, y, X_TC2);
      run_block(d, X_TC2, 1'b0, 1'b1, H_TC2, 1'b0, y);
      chk("hload_accept_h", d, y, Y_1);

      // Clear with accumulating accept: clear wins, product is X*H.
      run_block(d, X_TC2, 1'b1, 1'b0, '0, 1'b1, y);
      chk("clear_accept", d, y, Y_1);

      // Clear during BUSY: Y reads zero, then the new product (ONE*H = H).
      start(d, ONE, 1'b0, 1'b0, '0, 1'b0);
      tick();
      iClear = 1'b1;
      tick();
      iClear = 1'b0;
      chk("clear_busy_zero", d, res[d], 0);
      wait_done(d, y);
      chk("clear_busy_result", d, y, H_TC2);

      // Clear on the completion edge: the completion wins.
      start(d, X_TC2, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < n - 1; i++) tick();
      iClear = 1'b1;
      tick();
      iClear = 1'b0;
      chk("clear_done_valid", d, rv[d], 1);
      chk("clear_done_result", d, res[d], Y_1);

      // Reset halfway through an operation.
      tick();
      start(d, X_TC2, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < n / 2; i++) tick();
      iRst = 1'b1;
      tick();
      chk("rst_mid_valid", d, rv[d], 0);
      chk("rst_mid_result", d, res[d], 0);
      chk("rst_mid_ready", d, rdy[d], 1);
      chk("rst_mid_busy", d, busy[d], 0);
      iRst = 1'b0;
      p = 0;
      for (int i = 0; i < n + 3; i++) begin
        tick();
        if (rv[d]) p++;
      end
      chk("rst_mid_no_pulse", d, p, 0);

      // Random chains against the reference model (key is zero after reset).
      iClear = 1'b1;
      tick();
      iClear = 1'b0;
      my = '0;
      hc = '0;
      iters = (d == 0) ? 150 : 1000;
      for (int it = 0; it < iters; it++) begin
        hl  = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (hl) hc = rand128();
        x   = rand128();
        acc = 1'($urandom_range(0, 1));
        run_block(d, x, acc, hl, hc, 1'b0, y);
        my = gf_ref(x ^ (acc ? my : 128'h0), hc);
        chk("random", d, y, my);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gfmul_digit.md
# gfmul_digit

Parametrised digit-serial GF(2^128) multiplier for the GHASH path of the AES-GCM core. It computes the GCM field product of a 128-bit block with a stored hash key H, processing DIGIT bits per cycle. An optional accumulate mode computes the GHASH recurrence Y <- (Y ^ X)·H in place, so the GCM controller streams AAD, ciphertext and length blocks without external XOR logic. It replaces the fixed 1-bit multiplier with a handshaked, width-configurable unit.

## Interface
- DIGIT, default 1: bits of X consumed per cycle; legal values 1, 2, 4, 8, 16, 32. Other values are rejected at elaboration.
- N (localparam) = 128/DIGIT: number of compute cycles.
- iClk  in  1  clock; all state updates on the rising edge.
- iRst  in  1  synchronous, active-high reset.
- iH  in  [0:127]  hash key; bit 0 is the x^0 coefficient.
- iH_load  in  1  load iH into the key register.
- iX  in  [0:127]  input block, GCM bit order.
- iX_valid  in  1  block offered.
- oX_ready  out  1  block accepted when iX_valid & oX_ready.
- iAccum  in  1  sampled at accept: 1 = multiplicand is X ^ Y, 0 = X.
- iClear  in  1  clear the accumulator Y to zero.
- oResult  out  [0:127]  Y, the last product; holds until the next completion.
- oResult_valid  out  1  one-cycle pulse when Y is updated.
- oBusy  out  1  high while in BUSY.

## Operation
- States:
  - IDLE: oX_ready = 1.
  - BUSY: oX_ready = 0, oBusy = 1.
  - DONE: oX_ready = 1, oResult_valid = 1, one cycle only.
- Accept (IDLE or DONE, iX_valid = 1):
  - A <- iX ^ (iAccum ? Y : 0); Z <- 0; V <- H; cnt <- 0; go to BUSY.
- BUSY step, for each of the DIGIT bits i = cnt·DIGIT + k, with k = 0..DIGIT-1 in order:
  - if A[i] then Z ^= V.
  - V <- (V >> 1) ^ (V[127] ? R : 0), where R = E1 followed by 120 zero bits.
- After each step, cnt increments. When the step at cnt = N-1 finishes: Y <- Z, go to DONE.
- Leaving DONE: go to BUSY if a new block is accepted that cycle, otherwise go to IDLE.
- Key register:
  - iH_load in IDLE or DONE writes H.
  - iH_load in BUSY is ignored; the key is stable during an operation.
  - iH_load together with an accept: the new iH is used for that operation (bypass into V).
- iClear:
  - Sets Y to 0 on the next edge in any state.
  - Together with an accept where iAccum = 1: the clear wins, so A = X.
  - During BUSY: Y is zero until completion, then holds the new product.
  - Together with a completion: the completion wins, Y = product.
- All arithmetic is carry-less XOR; widths are fixed at 128 bits. cnt is clog2(N)+1 bits wide and never wraps.

## Timing
- Reset values:
  - state = IDLE, so oX_ready = 1.
  - oBusy = 0, oResult_valid = 0.
  - oResult = 0 (Y = 0), H = 0, cnt = 0.
- Accept on edge E0. Compute runs on edges E1..EN. oResult_valid is high in the cycle after EN. oResult is valid from that cycle.
- Back-to-back throughput: one block every N+1 cycles. The next accept may occur in the DONE cycle.
- iRst mid-operation: the operation is aborted with no completion pulse, and all registers return to reset values.
- iX, iAccum and iH are sampled only at the edges defined above; they are don't-care otherwise.

## Structure
- Shared package gcm_pkg holds:
  - the constant GF128_R (E1 followed by 120 zeros);
  - the function gf128_shr (multiply by x with reduction);
  - the legal DIGIT list check.
- One sub-module, gfmul_digit_step: a combinational DIGIT-bit unrolled step with inputs Z, V, A-slice and outputs Z', V'.
- The top level holds the FSM, counter, and the H, A, Y registers.

## Test plan
- Run every scenario for DIGIT in {1, 8, 32}.
- Identity:
  - H = 80000000000000000000000000000000, X = 0388dace60b6a392f328c2b971b2fe78, iAccum = 0.
  - Expect oResult = X and oResult_valid exactly N+1 cycles after accept.
- GHASH chain (GCM test case 2):
  - H = 66e94bd4ef8a2c3b884cfa59ca342b2e. Pulse iClear, then send X = 0388dace60b6a392f328c2b971b2fe78 with iAccum = 1.
  - Expect 5e2ec746917062882c85b0685353deb7.
  - Then send X = 00000000000000000000000000000080 with iAccum = 1.
  - Expect f38cbb1ad69223dcc3457ae5b6b0f885.
- Handshake:
  - Hold iX_valid continuously across 3 blocks.
  - Expect oX_ready low for exactly N cycles per block, accepts in the DONE cycles, and 3 pulses spaced N+1 cycles apart.
- Key and clear corners:
  - iH_load during BUSY leaves the result unchanged.
  - iH_load together with an accept uses the new H.
  - iClear together with an accept where iAccum = 1 gives X·H.
- Reset mid-operation:
  - Assert iRst at cnt = N/2.
  - Expect no oResult_valid, oResult = 0, oX_ready = 1 in the next cycle.
- Random:
  - 1000 random (H, X, iAccum) sequences against a bit-serial reference model.
